aes_inv_key_gen: RTL and testbench
==================================

# aes_inv_key_gen

AES-128 inverse key schedule generator for the MAC decryption datapath. It takes the cipher key and runs the forward expansion once, one round per cycle, to reach round key 10. It then walks the schedule backwards, one round key per request, 10 down to 0. It is the decrypt-side counterpart of the forward per-round key generator and feeds the inverse AES core in the order that core consumes keys.

## Interface
- Parameters: none. AES-128 only; round count comes from the shared package.
- pClk  in  1  baseband clock; single clock domain.
- sRst  in  1  reset, synchronous, active-high; overrides every other input.
- enable  in  1  clock enable; when low, all state and outputs hold and all inputs are ignored.
- aesKey  in  128  cipher key; word j at [32j+31:32j], byte 0 of each word at the low bits.
- keyStart  in  1  single-cycle pulse; latch aesKey and start expansion.
- keyNext  in  1  consumer has taken roundKey; step to the previous round.
- rewind  in  1  restart the backward walk at round 10 (active only with the macro).
- roundKey  out  128  current round key, same word/byte layout as aesKey.
- roundIdx  out  4  index of roundKey, 10..0.
- keyValid  out  1  roundKey/roundIdx are valid.
- busy  out  1  forward expansion in progress.

## Operation
- FSM states: IDLE, EXPAND, READY. Reset state is IDLE with roundKey=0, roundIdx=0, keyValid=0, busy=0 and the round counter at 0.
- IDLE:
  - keyStart: keyReg<=aesKey, cnt<=0, go to EXPAND.
  - keyNext is ignored.
- EXPAND (busy=1):
  - Each cycle: keyReg<=fwd(keyReg, rcon[cnt]), cnt++.
  - After the cnt=9 step: roundIdx<=10, go to READY.
- READY (keyValid=1):
  - keyNext with roundIdx>0: keyReg<=inv(keyReg, rcon[roundIdx-1]), roundIdx--.
  - keyNext with roundIdx=0: go to IDLE, keyValid<=0.
- fwd step:
  - n0 = w0 ^ RotSub(w3) ^ rcon.
  - n1 = w1 ^ n0; n2 = w2 ^ n1; n3 = w3 ^ n2.
- inv step:
  - p3 = w3 ^ w2; p2 = w2 ^ w1; p1 = w1 ^ w0.
  - p0 = w0 ^ RotSub(p3) ^ rcon.
- RotSub(x): per-byte SBox of x, rotated right by 8 bits, so byte0 of the result is S(byte1). rcon is XORed into bits [7:0].
- rcon table: 01,02,04,08,10,20,40,80,1b,36 for index 0..9.
- Only one 4-byte SBox bank is instantiated. Its input is muxed between w3 (EXPAND) and w3^w2 (READY).
- keyStart in any state aborts the current activity and restarts expansion; busy stays high and keyValid drops the next cycle.
- keyStart and keyNext in the same cycle: keyStart wins.
- keyNext while keyValid=0 is ignored.

## Timing
- keyStart sampled at cycle 0:
  - busy=1 during cycles 1..10.
  - keyValid=1 with roundIdx=10 from cycle 11.
  - Stalls on enable=0 extend this count one-for-one.
- keyNext has 1-cycle latency: the new key and index are visible the cycle after keyNext is sampled. keyNext may be held high every cycle; 11 consecutive accepts deliver keys 10..0 and return to IDLE.
- sRst mid-operation: the next cycle matches the reset values; no partial key is ever presented.

## Configuration
- AES_INV_KEY_REWIND_EN defined:
  - A 128-bit cache register stores round key 10 when EXPAND completes. The cache is marked valid then and invalidated by sRst or keyStart.
  - rewind with the cache valid, in READY or IDLE: next cycle roundKey=cache, roundIdx=10, keyValid=1. Used for back-to-back MPDUs under the same key.
  - rewind outranks keyNext; keyStart outranks rewind. rewind with the cache invalid is ignored.
- Not defined: no cache register; the rewind port exists but is ignored.

## Structure
- Shared package aes_pkg:
  - AES_NR=10.
  - rcon lookup function.
  - FSM state enum.
  - RotSub word helper.
- One natural sub-module, aes_inv_key_round: combinational fwd/inv step with the shared SBox bank (existing aesSBox ×4) and a mode select.
- The top level holds the FSM, counter, key register and optional cache.

## Test plan
- FIPS-197 key: aesKey=128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b with keyStart -> at cycle 11, keyValid=1, roundIdx=10, roundKey=128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0.
- Same key, keyNext held high -> round 1 key 128'h05766c2a_3939a323_b12c5488_17fefaa0, then round 0 equal to aesKey, then keyValid=0 in IDLE. The full sequence matches a reference model.
- keyStart during READY at roundIdx=4 with a new key -> keyValid drops the next cycle, then the new round-10 key appears 11 cycles after keyStart. keyStart plus keyNext in the same cycle -> restart only.
- enable low for 3 cycles mid-EXPAND and mid-walk -> all outputs frozen; keyValid appears at cycle 14.
- sRst asserted at EXPAND cycle 5 -> the next cycle shows roundKey=0, roundIdx=0, keyValid=0, busy=0; a later keyNext is ignored.
- With AES_INV_KEY_REWIND_EN: walk to roundIdx=3, assert rewind+keyNext -> roundIdx=10 with the FIPS round-10 key. After keyStart, rewind during EXPAND is ignored.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule blocks.
// Contents: round count, bus widths, FSM state enum, packed round-key
// layout, rcon lookup and the RotWord step applied after the SBox bank.
package aes_pkg;

  localparam int unsigned AES_NR = 10;
  localparam int unsigned KEY_W  = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } aesStateT;

  // Word 0 sits at the low bits, matching the aesKey/roundKey bus layout.
  typedef struct packed {
    logic [WORD_W-1:0] w3;
    logic [WORD_W-1:0] w2;
    logic [WORD_W-1:0] w1;
    logic [WORD_W-1:0] w0;
  } aesKeyT;

  // Round constant for forward step idx (0..9); out-of-range gives 0.
  function automatic logic [BYTE_W-1:0] rcon(input logic [IDX_W-1:0] idx);
    logic [BYTE_W-1:0] r;
    case (idx)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Rotate an already-substituted word right by one byte: byte0 = S(byte1).
  function automatic logic [WORD_W-1:0] rotSub(input logic [WORD_W-1:0] subWord);
    return {subWord[BYTE_W-1:0], subWord[WORD_W-1:BYTE_W]};
  endfunction

endpackage

// File: rtl/aes_inv_key_round.sv
// One AES-128 key-schedule step, forward or inverse, sharing one 4-byte
// SBox bank between the two directions.
// Ports: invMode (1 = previous round key, 0 = next round key),
//        rconByte (round constant for the step), keyIn (current round key),
//        stepKey_c (resulting round key, combinational).
module aes_inv_key_round
  import aes_pkg::*;
(
  input  logic              invMode,
  input  logic [BYTE_W-1:0] rconByte,
  input  logic [KEY_W-1:0]  keyIn,
  output logic [KEY_W-1:0]  stepKey_c
);

  aesKeyT            cur;
  aesKeyT            nxt;
  logic [WORD_W-1:0] sboxIn;
  logic [WORD_W-1:0] sboxOut;
  logic [WORD_W-1:0] mixWord;

  assign cur = keyIn;

  // Going backwards, the previous w3 is recovered as w3^w2 before substitution.
  assign sboxIn = invMode ? (cur.w3 ^ cur.w2) : cur.w3;

  for (genvar b = 0; b < 4; b++) begin : gSBox
    aesSBox uSBox (
      .sIn    (sboxIn[BYTE_W*b +: BYTE_W]),
      .sOut_c (sboxOut[BYTE_W*b +: BYTE_W])
    );
  end

  assign mixWord = rotSub(sboxOut) ^ {24'h000000, rconByte};

  // Word recurrence: forward chains w0 up to w3, inverse undoes it.
  always_comb begin
    nxt = cur;
    if (invMode) begin
      nxt.w3 = cur.w3 ^ cur.w2;
      nxt.w2 = cur.w2 ^ cur.w1;
      nxt.w1 = cur.w1 ^ cur.w0;
      nxt.w0 = cur.w0 ^ mixWord;
    end else begin
      nxt.w0 = cur.w0 ^ mixWord;
      nxt.w1 = cur.w1 ^ nxt.w0;
      nxt.w2 = cur.w2 ^ nxt.w1;
      nxt.w3 = cur.w3 ^ nxt.w2;
    end
  end

  assign stepKey_c = nxt;

endmodule

// File: rtl/aes_sbox.sv
// AES forward SBox, one byte, pure combinational table lookup.
// Ports: sIn (byte to substitute), sOut_c (substituted byte).
module aesSBox (
  input  logic [7:0] sIn,
  output logic [7:0] sOut_c
);

  // Entry 0x00 is the most significant byte of the table.
  localparam logic [2047:0] SBOX_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign sOut_c = SBOX_TAB[{8'hff - sIn, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_key_gen.sv
// AES-128 inverse key schedule generator: expands the cipher key forward
// to round key 10 (one round per cycle), then steps back one round key per
// keyNext, 10 down to 0, for the inverse AES core.
// Ports: pClk, sRst (sync, active-high), enable (clock enable),
//        aesKey/keyStart (load key and expand), keyNext (step back),
//        rewind (reload cached round key 10),
//        roundKey/roundIdx/keyValid (current key), busy (expanding).
// Build option: AES_INV_KEY_REWIND_EN adds the round-10 cache used by rewind;
// without it the rewind input is ignored.
module aes_inv_key_gen
  import aes_pkg::*;
(
  input  logic             pClk,
  input  logic             sRst,
  input  logic             enable,
  input  logic [KEY_W-1:0] aesKey,
  input  logic             keyStart,
  input  logic             keyNext,
  input  logic             rewind,
  output logic [KEY_W-1:0] roundKey,
  output logic [IDX_W-1:0] roundIdx,
  output logic             keyValid,
  output logic             busy
);

  aesStateT          state;
  logic [IDX_W-1:0]  cnt;
  logic              invMode_c;
  logic [BYTE_W-1:0] rconSel_c;
  logic [KEY_W-1:0]  stepKey_c;

  // roundKey doubles as the working key register in every state.
  assign invMode_c = (state != EXPAND);
  assign rconSel_c = invMode_c ? rcon(IDX_W'(roundIdx - IDX_W'(1))) : rcon(cnt);

  aes_inv_key_round uRound (
    .invMode   (invMode_c),
    .rconByte  (rconSel_c),
    .keyIn     (roundKey),
    .stepKey_c (stepKey_c)
  );

`ifdef AES_INV_KEY_REWIND_EN
  logic [KEY_W-1:0] cacheKey;
  logic             cacheValid;
  logic             rewindHit_c;

  assign rewindHit_c = rewind && cacheValid && (state != EXPAND);
`else
  logic unusedRewind;

  assign unusedRewind = rewind;
`endif

  // Control FSM, counter, key register and optional round-10 cache.
  always_ff @(posedge pClk) begin
    if (sRst) begin
      state    <= IDLE;
      roundKey <= '0;
      roundIdx <= '0;
      cnt      <= '0;
      keyValid <= 1'b0;
      busy     <= 1'b0;
`ifdef AES_INV_KEY_REWIND_EN
      cacheKey   <= '0;
      cacheValid <= 1'b0;
`endif
    end else if (enable) begin
      if (keyStart) begin
        state    <= EXPAND;
        roundKey <= aesKey;
        roundIdx <= '0;
        cnt      <= '0;
        keyValid <= 1'b0;
        busy     <= 1'b1;
`ifdef AES_INV_KEY_REWIND_EN
        cacheValid <= 1'b0;
`endif
      end
`ifdef AES_INV_KEY_REWIND_EN
      else if (rewindHit_c) begin
        state    <= READY;
        roundKey <= cacheKey;
        roundIdx <= IDX_W'(AES_NR);
        keyValid <= 1'b1;
        busy     <= 1'b0;
      end
`endif
      else begin
        case (state)
          IDLE: begin
          end
          EXPAND: begin
            roundKey <= stepKey_c;
            cnt      <= cnt + IDX_W'(1);
            if (cnt == IDX_W'(AES_NR - 1)) begin
              state    <= READY;
              roundIdx <= IDX_W'(AES_NR);
              keyValid <= 1'b1;
              busy     <= 1'b0;
`ifdef AES_INV_KEY_REWIND_EN
              cacheKey   <= stepKey_c;
              cacheValid <= 1'b1;
`endif
            end
          end
          READY: begin
            if (keyNext) begin
              if (roundIdx != '0) begin
                roundKey <= stepKey_c;
                roundIdx <= roundIdx - IDX_W'(1);
              end else begin
                state    <= IDLE;
                keyValid <= 1'b0;
              end
            end
          end
          default: begin
            state    <= IDLE;
            keyValid <= 1'b0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_inv_key_gen.sv
// Self-checking bench for aes_inv_key_gen. Reference: FIPS-197 key expansion
// with an SBox derived from GF(2^8) inversion plus the affine map.
module tb_aes_inv_key_gen;

  localparam logic [127:0] FIPS_KEY = 128'h3c4fcf09_8815f7ab_a6d2ae28_16157e2b;
  localparam logic [127:0] FIPS_R10 = 128'ha60c63b6_c80c3fe1_8925eec9_a8f914d0;
  localparam logic [127:0] FIPS_R1  = 128'h05766c2a_3939a323_b12c5488_17fefaa0;

  logic         pClk;
  logic         sRst;
  logic         enable;
  logic [127:0] aesKey;
  logic         keyStart;
  logic         keyNext;
  logic         rewind;
  logic [127:0] roundKey;
  logic [3:0]   roundIdx;
  logic         keyValid;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int mIdx   = 0;
  logic [7:0]   sboxTab [256];
  logic [127:0] rk      [11];

  aes_inv_key_gen dut (
    .pClk     (pClk),
    .sRst     (sRst),
    .enable   (enable),
    .aesKey   (aesKey),
    .keyStart (keyStart),
    .keyNext  (keyNext),
    .rewind   (rewind),
    .roundKey (roundKey),
    .roundIdx (roundIdx),
    .keyValid (keyValid),
    .busy     (busy)
  );

  initial pClk = 1'b0;
  always #5 pClk = ~pClk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic buildSbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sboxTab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                 ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // FIPS-197 KeyExpansion; bytes listed low-first inside each word.
  task automatic expandModel(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[7:0], t[31:8]};
        t = {sboxTab[t[31:24]], sboxTab[t[23:16]], sboxTab[t[15:8]], sboxTab[t[7:0]]};
        t[7:0] = t[7:0] ^ rc;
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endtask

  task automatic tick();
    @(posedge pClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkBit(input string tag, input logic obs, input logic exp);
    chk(tag, 128'(obs), 128'(exp));
  endtask

  task automatic checkIdle(input string tag);
    chk({tag, "_key"}, roundKey, 128'h0);
    chk({tag, "_idx"}, 128'(roundIdx), 128'h0);
    chkBit({tag, "_valid"}, keyValid, 1'b0);
    chkBit({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic checkReady(input int idx);
    chkBit($sformatf("valid_r%0d", idx), keyValid, 1'b1);
    chkBit($sformatf("busy_r%0d", idx), busy, 1'b0);
    chk($sformatf("idx_r%0d", idx), 128'(roundIdx), 128'(idx));
    chk($sformatf("key_r%0d", idx), roundKey, rk[idx]);
  endtask

  // keyStart (optionally with keyNext) then 10 busy cycles and round 10.
  task automatic startKey(input logic [127:0] key, input logic withNext);
    aesKey   = key;
    keyStart = 1'b1;
    keyNext  = withNext;
    expandModel(key);
    mIdx = 10;
    tick();
    keyStart = 1'b0;
    keyNext  = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      chkBit($sformatf("exp_busy_c%0d", c), busy, 1'b1);
      chkBit($sformatf("exp_valid_c%0d", c), keyValid, 1'b0);
      tick();
    end
    checkReady(10);
  endtask

  task automatic walk(input int target, input bit gaps);
    int guard = 0;
    logic took;
    while (mIdx > target && guard < 400) begin
      took = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      keyNext = took;
      tick();
      if (took) mIdx--;
      checkReady(mIdx);
      guard++;
    end
    keyNext = 1'b0;
    if (guard >= 400) chk("walk_timeout", 128'(mIdx), 128'(target));
  endtask

  task automatic finishWalk(input string tag);
    keyNext = 1'b1;
    tick();
    keyNext = 1'b0;
    chkBit({tag, "_end_valid"}, keyValid, 1'b0);
    chkBit({tag, "_end_busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [127:0] k;
    buildSbox();
    sRst = 1'b1; enable = 1'b1; aesKey = '0;
    keyStart = 1'b0; keyNext = 1'b0; rewind = 1'b0;
    tick(); tick();
    checkIdle("reset");
    sRst = 1'b0;

    // keyNext in IDLE does nothing
    keyNext = 1'b1; tick(); keyNext = 1'b0;
    checkIdle("idle_next");

    // FIPS-197 vector, keyNext held high through the whole walk
    startKey(FIPS_KEY, 1'b0);
    chk("fips_r10", roundKey, FIPS_R10);
    walk(1, 1'b0);
    chk("fips_r1", roundKey, FIPS_R1);
    walk(0, 1'b0);
    chk("fips_r0", roundKey, FIPS_KEY);
    finishWalk("fips");

    // restart at round 4 with keyStart+keyNext together
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    startKey(k, 1'b0);
    walk(4, 1'b1);
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    startKey(k, 1'b1);
    walk(0, 1'b1);
    finishWalk("restart");

    // enable low for 3 cycles mid-EXPAND: round 10 lands at cycle 14
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    expandModel(k);
    mIdx = 10;
    aesKey = k; keyStart = 1'b1;
    tick();
    keyStart = 1'b0;
    tick(); tick(); tick();
    enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chkBit("stall_exp_busy", busy, 1'b1);
      chkBit("stall_exp_valid", keyValid, 1'b0);
    end
    enable = 1'b1;
    repeat (6) tick();
    chkBit("stall_c13_valid", keyValid, 1'b0);
    tick();
    checkReady(10);

    // enable low for 3 cycles mid-walk with keyNext held
    walk(7, 1'b0);
    keyNext = 1'b1; enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkReady(7);
    end
    enable = 1'b1;
    tick();
    mIdx = 6;
    checkReady(6);
    keyNext = 1'b0;
    walk(0, 1'b1);
    finishWalk("stall");

    // sRst at EXPAND cycle 5, then keyNext ignored
    aesKey = {$urandom(), $urandom(), $urandom(), $urandom()};
    keyStart = 1'b1;
    tick();
    keyStart = 1'b0;
    repeat (4) tick();
    sRst = 1'b1;
    tick();
    sRst = 1'b0;
    checkIdle("mid_rst");
    keyNext = 1'b1; tick(); keyNext = 1'b0;
    checkIdle("rst_next");

    // rewind together with keyNext at round 3
    startKey(FIPS_KEY, 1'b0);
    walk(3, 1'b1);
    rewind = 1'b1; keyNext = 1'b1;
    tick();
    rewind = 1'b0; keyNext = 1'b0;
`ifdef AES_INV_KEY_REWIND_EN
    mIdx = 10;
    checkReady(10);
    chk("rewind_r10", roundKey, FIPS_R10);
    walk(0, 1'b0);
    finishWalk("rw");
    rewind = 1'b1; tick(); rewind = 1'b0;
    checkReady(10);
    // rewind during EXPAND is ignored
    aesKey = FIPS_KEY; keyStart = 1'b1;
    tick();
    keyStart = 1'b0; rewind = 1'b1;
    tick();
    rewind = 1'b0;
    chkBit("rw_exp_busy", busy, 1'b1);
    chkBit("rw_exp_valid", keyValid, 1'b0);
    repeat (8) tick();
    chkBit("rw_c10_valid", keyValid, 1'b0);
    tick();
    checkReady(10);
    walk(0, 1'b1);
    finishWalk("rw2");
`else
    mIdx = 2;
    checkReady(2);
    walk(0, 1'b0);
    finishWalk("norw");
    rewind = 1'b1; tick(); rewind = 1'b0;
    chkBit("norw_idle_valid", keyValid, 1'b0);
`endif

    // random keys, random keyNext gaps
    for (int n = 0; n < 4; n++) begin
      startKey({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0);
      walk(0, 1'b1);
      finishWalk($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
